// File: rtl/iq_dispatch_arbiter.sv
// rtl/iq_dispatch_arbiter.sv - credit-based round-robin dispatch into N_IQ issue queues.
// Optional stall counter enabled by defining IQ_DISPATCH_STALL_CNT_EN.
module iq_dispatch_arbiter #(
    parameter int N_IQ         = 2,
    parameter int INST_ID_BITS = 6,
    parameter int QUEUE_SIZE   = 4,
    localparam int CW          = $clog2(QUEUE_SIZE + 1),
    localparam int PW          = (N_IQ > 1) ? $clog2(N_IQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [INST_ID_BITS-1:0] disp_inst_id,
    input  logic [31:0]             disp_inst,
    input  logic [63:0]             disp_pc,
    input  logic [N_IQ-1:0]         disp_iq_mask,
    input  logic                    flush,
    input  logic [N_IQ-1:0]         iq_release,
    output logic [N_IQ-1:0]         iq_inst_valid,
    output logic [INST_ID_BITS-1:0] iq_inst_id,
    output logic [31:0]             iq_inst,
    output logic [63:0]             iq_pc,
    output logic [N_IQ*CW-1:0]      iq_credit,
    output logic                    credit_err,
    output logic [31:0]             stall_cnt
);
    localparam logic [CW-1:0] FULL = CW'(QUEUE_SIZE);
    localparam logic [PW:0]   NQ   = (PW + 1)'(N_IQ);

    logic [CW-1:0]           r_credit [N_IQ];
    logic [PW-1:0]           r_rr_ptr;
    logic                    r_credit_err;
    logic [N_IQ-1:0]         r_iq_inst_valid;
    logic [INST_ID_BITS-1:0] r_iq_inst_id;
    logic [31:0]             r_iq_inst;
    logic [63:0]             r_iq_pc;

    logic [N_IQ-1:0]   w_elig;
    logic [2*N_IQ-1:0] w_dbl;
    logic [N_IQ-1:0]   w_rot;
    logic              w_found;
    logic              w_fire;
    logic [PW:0]       w_sum;
    logic [PW-1:0]     w_grant;
    logic [PW-1:0]     w_next_rr;
    logic [N_IQ-1:0]   w_grant_oh;

    // Rotate eligibility so bit 0 is rr_ptr, take the lowest set bit, rotate back.
    always_comb begin
        w_elig     = '0;
        w_found    = 1'b0;
        w_sum      = '0;
        w_grant    = '0;
        w_next_rr  = '0;
        w_grant_oh = '0;
        for (int i = 0; i < N_IQ; i++) begin
            w_elig[i] = disp_iq_mask[i] && (r_credit[i] != '0);
        end
        w_dbl = {w_elig, w_elig} >> r_rr_ptr;
        w_rot = w_dbl[N_IQ-1:0];
        for (int k = 0; k < N_IQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (PW + 1)'(k);
            end
        end
        if (w_sum >= NQ) begin
            w_sum = w_sum - NQ;
        end
        w_grant    = w_sum[PW-1:0];
        disp_ready = !flush && w_found;
        w_fire     = disp_valid && disp_ready;
        w_sum      = {1'b0, w_grant} + (PW + 1)'(1);
        w_next_rr  = (w_sum >= NQ) ? '0 : w_sum[PW-1:0];
        for (int i = 0; i < N_IQ; i++) begin
            w_grant_oh[i] = w_fire && (w_grant == PW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IQ; i++) begin
                r_credit[i] <= FULL;
            end
            r_rr_ptr        <= '0;
            r_credit_err    <= 1'b0;
            r_iq_inst_valid <= '0;
            r_iq_inst_id    <= '0;
            r_iq_inst       <= '0;
            r_iq_pc         <= '0;
        end else begin
            // A grant and a release together cancel; an overflowing release is dropped and flagged.
            for (int i = 0; i < N_IQ; i++) begin
                if (w_grant_oh[i] && !iq_release[i]) begin
                    r_credit[i] <= r_credit[i] - CW'(1);
                end else if (!w_grant_oh[i] && iq_release[i]) begin
                    if (r_credit[i] == FULL) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_credit[i] <= r_credit[i] + CW'(1);
                    end
                end
            end
            r_iq_inst_valid <= w_grant_oh;
            if (w_fire) begin
                r_rr_ptr     <= w_next_rr;
                r_iq_inst_id <= disp_inst_id;
                r_iq_inst    <= disp_inst;
                r_iq_pc      <= disp_pc;
            end
        end
    end

    always_comb begin
        iq_credit = '0;
        for (int i = 0; i < N_IQ; i++) begin
            iq_credit[i*CW +: CW] = r_credit[i];
        end
    end

    assign iq_inst_valid = r_iq_inst_valid;
    assign iq_inst_id    = r_iq_inst_id;
    assign iq_inst       = r_iq_inst;
    assign iq_pc         = r_iq_pc;
    assign credit_err    = r_credit_err;

`ifdef IQ_DISPATCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (disp_valid && !disp_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_iq_dispatch_arbiter.sv
// tb/tb_iq_dispatch_arbiter.sv - scoreboard bench for iq_dispatch_arbiter.
module tb_iq_dispatch_arbiter;
    localparam int N   = 2;
    localparam int IDB = 6;
    localparam int QS  = 4;
    localparam int CW  = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           disp_valid = 1'b0;
    logic           disp_ready;
    logic [IDB-1:0] disp_inst_id = '0;
    logic [31:0]    disp_inst = '0;
    logic [63:0]    disp_pc = '0;
    logic [N-1:0]   disp_iq_mask = '0;
    logic           flush = 1'b0;
    logic [N-1:0]   iq_release = '0;
    logic [N-1:0]   iq_inst_valid;
    logic [IDB-1:0] iq_inst_id;
    logic [31:0]    iq_inst;
    logic [63:0]    iq_pc;
    logic [N*CW-1:0] iq_credit;
    logic           credit_err;
    logic [31:0]    stall_cnt;

    iq_dispatch_arbiter #(.N_IQ(N), .INST_ID_BITS(IDB), .QUEUE_SIZE(QS)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_inst_id(disp_inst_id), .disp_inst(disp_inst), .disp_pc(disp_pc),
        .disp_iq_mask(disp_iq_mask), .flush(flush), .iq_release(iq_release),
        .iq_inst_valid(iq_inst_valid), .iq_inst_id(iq_inst_id), .iq_inst(iq_inst),
        .iq_pc(iq_pc), .iq_credit(iq_credit), .credit_err(credit_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   v;
        logic [IDB-1:0] id;
        logic [31:0]    inst;
        logic [63:0]    pc;
    } exp_t;

    exp_t    sbq[$];
    int      errs   = 0;
    int      checks = 0;
    int      m_credit[N];
    int      m_rr;
    bit      m_err;
    longint  m_stall;
    logic [IDB-1:0] h_id;
    logic [31:0]    h_inst;
    logic [63:0]    h_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_stall();
`ifdef IQ_DISPATCH_STALL_CNT_EN
        return 64'(m_stall);
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_credit[i] = QS;
        m_rr    = 0;
        m_err   = 1'b0;
        m_stall = 0;
    endtask

    task automatic drive_idle();
        disp_valid   = 1'b0;
        disp_iq_mask = '0;
        flush        = 1'b0;
        iq_release   = '0;
    endtask

    // One dispatch-stage cycle: drive, predict from the queue-level rules, update the model.
    task automatic step(input bit v, input logic [N-1:0] mask, input bit fl, input logic [N-1:0] rel);
        int   g;
        bit   gr;
        exp_t e;
        @(negedge clk);
        disp_valid   = v;
        disp_iq_mask = mask;
        flush        = fl;
        iq_release   = rel;
        disp_inst_id = IDB'($urandom);
        disp_inst    = $urandom;
        disp_pc      = {$urandom, $urandom};
        #1;
        g = -1;
        if (!fl) begin
            for (int k = 0; k < N; k++) begin
                int q;
                q = (m_rr + k) % N;
                if (g < 0 && mask[q] && m_credit[q] > 0) g = q;
            end
        end
        chk("disp_ready", 64'(disp_ready), 64'(g >= 0));
        if (v && g < 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (v && g >= 0) begin
            e.v    = N'(1) << g;
            e.id   = disp_inst_id;
            e.inst = disp_inst;
            e.pc   = disp_pc;
            sbq.push_back(e);
            m_rr = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            gr = v && (g == i);
            if (gr && !rel[i]) m_credit[i]--;
            else if (!gr && rel[i]) begin
                if (m_credit[i] == QS) m_err = 1'b1;
                else m_credit[i]++;
            end
        end
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        model_reset();
        #1;
        chk("rst_valid", 64'(iq_inst_valid), 64'd0);
        chk("rst_credit", 64'(iq_credit), 64'({3'(QS), 3'(QS)}));
        chk("rst_err", 64'(credit_err), 64'd0);
        chk("rst_id", 64'(iq_inst_id), 64'd0);
        chk("rst_inst", 64'(iq_inst), 64'd0);
        chk("rst_pc", iq_pc, 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        release_reset();
    endtask

    // Monitor: pops the scoreboard on every pulse and tracks the held broadcast values.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            h_id   = '0;
            h_inst = '0;
            h_pc   = '0;
        end else begin
            if (iq_inst_valid != '0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL spurious_pulse: got %0b expected none at %0t", iq_inst_valid, $time);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("pulse_onehot", 64'(iq_inst_valid), 64'(e.v));
                    chk("pulse_id", 64'(iq_inst_id), 64'(e.id));
                    chk("pulse_inst", 64'(iq_inst), 64'(e.inst));
                    chk("pulse_pc", iq_pc, e.pc);
                    h_id   = e.id;
                    h_inst = e.inst;
                    h_pc   = e.pc;
                end
            end else begin
                chk("hold_id", 64'(iq_inst_id), 64'(h_id));
                chk("hold_inst", 64'(iq_inst), 64'(h_inst));
                chk("hold_pc", iq_pc, h_pc);
            end
            for (int i = 0; i < N; i++) begin
                chk("credit", 64'(iq_credit[i*CW +: CW]), 64'(m_credit[i]));
            end
            chk("credit_err", 64'(credit_err), 64'(m_err));
            chk("stall_cnt", 64'(stall_cnt), exp_stall());
        end
    end

    initial begin
        logic [N-1:0] rel;
        model_reset();
        apply_reset();

        repeat (8) step(1'b1, 2'b11, 1'b0, 2'b00);
        step(1'b1, 2'b11, 1'b0, 2'b00);
        repeat (4) step(1'b0, 2'b00, 1'b0, 2'b11);
        step(1'b1, 2'b11, 1'b1, 2'b00);
        repeat (5) step(1'b1, 2'b00, 1'b0, 2'b00);
        step(1'b0, 2'b00, 1'b0, 2'b00);

        apply_reset();
        repeat (3) step(1'b1, 2'b01, 1'b0, 2'b00);
        step(1'b1, 2'b01, 1'b0, 2'b01);
        step(1'b0, 2'b00, 1'b0, 2'b00);

        apply_reset();
        step(1'b1, 2'b11, 1'b0, 2'b00);
        @(posedge clk);
        #3 rst = 1'b1;
        drive_idle();
        model_reset();
        #1;
        chk("async_valid", 64'(iq_inst_valid), 64'd0);
        chk("async_credit", 64'(iq_credit), 64'({3'(QS), 3'(QS)}));
        release_reset();
        step(1'b1, 2'b10, 1'b0, 2'b00);
        step(1'b0, 2'b00, 1'b0, 2'b00);

        apply_reset();
        repeat (400) begin
            rel = '0;
            for (int i = 0; i < N; i++) begin
                if ((m_credit[i] < QS && $urandom_range(0, 2) == 0) || $urandom_range(0, 49) == 0)
                    rel[i] = 1'b1;
            end
            step($urandom_range(0, 9) < 7, N'($urandom), $urandom_range(0, 9) == 0, rel);
        end
        step(1'b0, 2'b00, 1'b0, 2'b00);

        apply_reset();
        step(1'b0, 2'b00, 1'b0, 2'b10);
        repeat (3) step(1'b0, 2'b00, 1'b0, 2'b00);
        @(negedge clk);
        chk("err_sticky", 64'(credit_err), 64'd1);

        checks++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/iq_dispatch_arbiter.md
IQ_DISPATCH_ARBITER -- requirements
Module: iq_dispatch_arbiter

Interface
REQ-001 Parameter N_IQ, default 2, number of issue queues steered.
REQ-002 Parameter INST_ID_BITS, default 6, instruction ID width.
REQ-003 Parameter QUEUE_SIZE, default 4, slots per issue queue; CW = ceil(log2(QUEUE_SIZE+1)).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port disp_valid  input  1  dispatch stage offers an instruction.
REQ-007 Port disp_ready  output  1  arbiter accepts the offered instruction this cycle.
REQ-008 Port disp_inst_id  input  INST_ID_BITS  instruction ID.
REQ-009 Port disp_inst  input  32  instruction word.
REQ-010 Port disp_pc  input  64  program counter.
REQ-011 Port disp_iq_mask  input  N_IQ  bit i set: queue i can execute this instruction.
REQ-012 Port flush  input  1  pipeline flush; blocks dispatch this cycle.
REQ-013 Port iq_release  input  N_IQ  bit i pulse: queue i freed one slot.
REQ-014 Port iq_inst_valid  output  N_IQ  one-hot pulse writing queue i.
REQ-015 Port iq_inst_id  output  INST_ID_BITS  registered ID broadcast to all queues.
REQ-016 Port iq_inst  output  32  registered instruction broadcast.
REQ-017 Port iq_pc  output  64  registered PC broadcast.
REQ-018 Port iq_credit  output  N_IQ*CW  free-slot count per queue, queue i at bits [i*CW +: CW].
REQ-019 Port credit_err  output  1  sticky: release seen on a queue already at QUEUE_SIZE credits.

Function
REQ-020 Eligible(i) = disp_iq_mask[i] and credit[i] > 0.
REQ-021 disp_ready is combinational: !flush and at least one eligible queue; not dependent on disp_valid.
REQ-022 Dispatch fires when disp_valid && disp_ready.
REQ-023 Grant = first eligible queue scanning upward from rr_ptr with wrap at N_IQ.
REQ-024 On fire at cycle T, iq_inst_valid[grant] is 1 for exactly cycle T+1, and iq_inst_id/iq_inst/iq_pc hold the cycle-T disp values.
REQ-025 On fire, rr_ptr becomes (grant+1) mod N_IQ; otherwise rr_ptr holds.
REQ-026 With no fire, iq_inst_valid is all zero next cycle; iq_inst_id/iq_inst/iq_pc hold their previous values.
REQ-027 Back-to-back fires on consecutive cycles are supported, with no bubble.
REQ-028 credit[i] next = credit[i] - (granted i) + iq_release[i]; a simultaneous grant and release leaves the count unchanged.
REQ-029 A release on credit[i] == QUEUE_SIZE without a same-cycle grant leaves the count at QUEUE_SIZE and sets credit_err.
REQ-030 Credits never underflow, because a grant requires credit > 0.
REQ-031 Flush does not alter credits or rr_ptr; releases during flush are still counted.
REQ-032 disp_valid with disp_iq_mask == 0 never fires (disp_ready = 0), and this is not an error.

Reset
REQ-033 While rst is high: iq_inst_valid = 0, credit[i] = QUEUE_SIZE, rr_ptr = 0, credit_err = 0, and iq_inst_id/iq_inst/iq_pc = 0.
REQ-034 Reset asserted mid-operation discards any pending iq_inst_valid pulse immediately (asynchronously).
REQ-035 The first fire is possible in the first cycle after rst deasserts.

Configuration
REQ-036 Macro IQ_DISPATCH_STALL_CNT_EN defined: output stall_cnt (32 bits) counts cycles with disp_valid && !disp_ready, saturates at 0xFFFFFFFF, and resets to 0.
REQ-037 Macro not defined: stall_cnt still exists and is tied to 0, with no counter logic.

Verification
REQ-038 Reset, then mask=2'b11 with disp_valid held for 8 cycles and no release -> grants q0,q1,q0,q1,...; after 8 fires both credits are 0; disp_ready drops in cycle 9.
REQ-039 Mask=2'b01, credit0=1, fire with iq_release[0]=1 in the same cycle -> credit0 stays 1; iq_inst_valid=2'b01 next cycle with the matching ID/inst/PC.
REQ-040 Credits full (4,4), pulse iq_release=2'b10 -> credit1 stays 4; credit_err=1 and remains 1 until reset.
REQ-041 flush=1 with disp_valid=1 and mask=2'b11 -> disp_ready=0; iq_inst_valid=0 next cycle; credits and rr_ptr unchanged.
REQ-042 Assert rst in the cycle after a fire -> iq_inst_valid goes to 0 without waiting for a clock edge; credits return to 4,4.
REQ-043 With IQ_DISPATCH_STALL_CNT_EN defined, hold disp_valid=1 with mask=0 for 5 cycles -> stall_cnt=5; without the macro, stall_cnt=0.
